// File: rtl/conv_window_mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : conv_window_mac_seq
// Brief    : Time-multiplexed MAC over one KxK window, LANES products per beat,
//            with a saturated Q-format result.
// Revision : 1.0
// ============================================================================
module conv_window_mac_seq #(
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_BIT    = 8,
    parameter int KERNEL_SIZE = 5,
    parameter int LANES       = 5
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic                                            in_valid,
    output logic                                            in_ready,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]   in_weights,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]   in_pixels,
    output logic                                            out_valid,
    input  logic                                            out_ready,
    output logic [DATA_WIDTH-1:0]                           out_data,
    output logic                                            out_sat,
    output logic                                            busy
);

    localparam int C_TAPS      = KERNEL_SIZE * KERNEL_SIZE;
    localparam int C_BEATS     = (C_TAPS + LANES - 1) / LANES;
    localparam int C_ACC_WIDTH = DATA_WIDTH + 8;
    localparam int C_PAD_W     = C_BEATS * LANES * DATA_WIDTH;
    localparam int C_BEAT_W    = (C_BEATS > 1) ? $clog2(C_BEATS) : 1;

    localparam logic signed [C_ACC_WIDTH-1:0] C_SAT_MAX = C_ACC_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [C_ACC_WIDTH-1:0] C_SAT_MIN = ~C_SAT_MAX;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                         r_state;
    state_t                         w_state_next;
    logic [C_PAD_W-1:0]             r_weights;
    logic [C_PAD_W-1:0]             r_pixels;
    logic [C_BEAT_W-1:0]            r_beat;
    logic signed [C_ACC_WIDTH-1:0]  r_acc;
    logic [DATA_WIDTH-1:0]          r_out_data;
    logic                           r_out_sat;

    logic                           w_last_beat;
    logic signed [DATA_WIDTH-1:0]   w_lane_q [LANES];
    logic signed [C_ACC_WIDTH-1:0]  w_beat_sum;
    logic signed [C_ACC_WIDTH-1:0]  w_acc_next;
    logic [DATA_WIDTH-1:0]          w_sat_data;
    logic                           w_sat_flag;

    assign w_last_beat = (r_beat == C_BEAT_W'(C_BEATS - 1));

    // Windows shift down by one beat per MAC cycle, so lanes always read the
    // bottom LANES taps; zero padding above TAPS makes the tail lanes add 0.
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic signed [DATA_WIDTH-1:0]   w_wt;
        logic signed [DATA_WIDTH-1:0]   w_px;
        logic signed [2*DATA_WIDTH-1:0] w_prod;
        logic [DATA_WIDTH-2:0]          w_mag;

        assign w_wt        = r_weights[j*DATA_WIDTH +: DATA_WIDTH];
        assign w_px        = r_pixels[j*DATA_WIDTH +: DATA_WIDTH];
        assign w_prod      = w_wt * w_px;
        assign w_mag       = (DATA_WIDTH-1)'(w_prod >>> FRAC_BIT);
        assign w_lane_q[j] = {w_prod[2*DATA_WIDTH-1], w_mag};
    end

    always_comb begin
        w_beat_sum = '0;
        for (int j = 0; j < LANES; j++) begin
            w_beat_sum = w_beat_sum + C_ACC_WIDTH'(w_lane_q[j]);
        end
    end

    assign w_acc_next = r_acc + w_beat_sum;

    always_comb begin
        w_sat_data = w_acc_next[DATA_WIDTH-1:0];
        w_sat_flag = 1'b0;
        if (w_acc_next > C_SAT_MAX) begin
            w_sat_data = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            w_sat_flag = 1'b1;
        end else if (w_acc_next < C_SAT_MIN) begin
            w_sat_data = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            w_sat_flag = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) w_state_next = S_MAC;
            end
            S_MAC: begin
                if (w_last_beat) w_state_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_weights  <= '0;
            r_pixels   <= '0;
            r_beat     <= '0;
            r_acc      <= '0;
            r_out_data <= '0;
            r_out_sat  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_weights <= C_PAD_W'(in_weights);
                        r_pixels  <= C_PAD_W'(in_pixels);
                        r_beat    <= '0;
                        r_acc     <= '0;
                    end
                end
                S_MAC: begin
                    r_acc     <= w_acc_next;
                    r_weights <= r_weights >> (LANES * DATA_WIDTH);
                    r_pixels  <= r_pixels >> (LANES * DATA_WIDTH);
                    if (w_last_beat) begin
                        r_out_data <= w_sat_data;
                        r_out_sat  <= w_sat_flag;
                    end else begin
                        r_beat <= r_beat + C_BEAT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_data = r_out_data;
    assign out_sat  = r_out_sat;

endmodule
`default_nettype wire

// File: tb/tb_conv_window_mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_window_mac_seq
// Brief    : Directed vectors for conv_window_mac_seq (LANES=5 and LANES=4).
// Revision : 1.0
// ============================================================================
module tb_conv_window_mac_seq;

    localparam int C_TW = 25 * 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid, in_valid4;
    logic             in_ready, in_ready4;
    logic [C_TW-1:0]  in_weights, in_pixels;
    logic             out_valid, out_valid4;
    logic             out_ready;
    logic [15:0]      out_data, out_data4;
    logic             out_sat, out_sat4;
    logic             busy, busy4;

    int n_vec = 0;
    int n_err = 0;
    int lat;

    always #5 clk = ~clk;

    conv_window_mac_seq u_dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_weights (in_weights),
        .in_pixels  (in_pixels),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sat    (out_sat),
        .busy       (busy)
    );

    conv_window_mac_seq #(.LANES(4)) u_dut4 (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid4),
        .in_ready   (in_ready4),
        .in_weights (in_weights),
        .in_pixels  (in_pixels),
        .out_valid  (out_valid4),
        .out_ready  (out_ready),
        .out_data   (out_data4),
        .out_sat    (out_sat4),
        .busy       (busy4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [C_TW-1:0] fill(input logic [15:0] v);
        logic [C_TW-1:0] r;
        for (int i = 0; i < 25; i++) r[i*16 +: 16] = v;
        return r;
    endfunction

    // Present a window at a negedge, hold until accepted, return at cycle-1 negedge.
    task automatic send(input bit sel, input logic [C_TW-1:0] w, input logic [C_TW-1:0] x);
        int guard;
        in_weights = w;
        in_pixels  = x;
        if (sel) in_valid4 = 1'b1; else in_valid = 1'b1;
        guard = 0;
        while (!(sel ? in_ready4 : in_ready) && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 64) chk("accept_timeout", 32'(guard), 32'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        in_valid4 = 1'b0;
    endtask

    task automatic wait_valid(input bit sel, output int l);
        l = 1;
        while (!(sel ? out_valid4 : out_valid) && l < 64) begin
            @(negedge clk);
            l++;
        end
    endtask

    task automatic run_default(input string tag, input logic [15:0] w, input logic [15:0] x,
                               input logic [15:0] exp_d, input logic exp_s);
        int l;
        send(1'b0, fill(w), fill(x));
        wait_valid(1'b0, l);
        chk({tag, "_lat"}, 32'(l), 32'd6);
        chk({tag, "_data"}, 32'(out_data), 32'(exp_d));
        chk({tag, "_sat"}, 32'(out_sat), 32'(exp_s));
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [C_TW-1:0] ramp;
        reset      = 1'b1;
        in_valid   = 1'b1;
        in_valid4  = 1'b0;
        out_ready  = 1'b1;
        in_weights = fill(16'h0100);
        in_pixels  = fill(16'h0100);
        repeat (3) @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_sat", 32'(out_sat), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        run_default("unity", 16'h0100, 16'h0100, 16'h1900, 1'b0);
        run_default("neg",   16'h0200, 16'hFF00, 16'hCE00, 1'b0);
        run_default("satp",  16'h0100, 16'h7F00, 16'h7FFF, 1'b1);
        run_default("satn",  16'h0100, 16'h8100, 16'h8000, 1'b1);

        // Backpressure: 0.5 * 1.0 * 25 = 12.5
        out_ready = 1'b0;
        send(1'b0, fill(16'h0100), fill(16'h0080));
        wait_valid(1'b0, lat);
        chk("bp_lat", 32'(lat), 32'd6);
        for (int i = 0; i < 10; i++) begin
            in_valid   = i[0];
            in_weights = fill(16'h0300);
            in_pixels  = fill(16'h0300);
            @(negedge clk);
            chk("bp_data", 32'(out_data), 32'h0C80);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        in_weights = fill(16'h0100);
        in_pixels  = fill(16'h0100);
        @(negedge clk);
        chk("bp_idle_ready", 32'(in_ready), 32'd1);
        chk("bp_idle_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("bp_reaccept_busy", 32'(busy), 32'd1);
        in_valid = 1'b0;
        wait_valid(1'b0, lat);
        chk("bp_next_lat", 32'(lat), 32'd6);
        chk("bp_next_data", 32'(out_data), 32'h1900);
        @(negedge clk);

        // Partial last beat on the LANES=4 instance: sum of k for k=0..24 = 300.0
        for (int k = 0; k < 25; k++) ramp[k*16 +: 16] = 16'(k << 8);
        send(1'b1, fill(16'h0100), ramp);
        wait_valid(1'b1, lat);
        chk("part_lat", 32'(lat), 32'd8);
        chk("part_data", 32'(out_data4), 32'h7FFF);
        chk("part_sat", 32'(out_sat4), 32'd1);
        chk("part_acc", 32'(u_dut4.r_acc), 32'd76800);
        @(negedge clk);
        chk("part_pulse", 32'(out_valid4), 32'd0);

        // Reset during MAC cycle 3
        send(1'b0, fill(16'h0100), fill(16'h0100));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        run_default("post_rst", 16'h0100, 16'h0100, 16'h1900, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
